// File: rtl/pb_step_scheduler.sv
// Push-button step scheduler: synchronises N_REQ raw buttons, latches one pending
// press per button and grants them round-robin as one-cycle step enables.
module pb_step_scheduler #(
  parameter int N_REQ = 4,
  parameter int GAP   = 2,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] pb,
  input  logic             clr_ovf,
  output logic             step_en,
  output logic [ID_W-1:0]  step_id,
  output logic [N_REQ-1:0] pending,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [3:0]      HOLD_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic [ID_W-1:0] LAST_RST  = ID_W'(N_REQ - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic             step_en_q, step_en_d;
  logic [ID_W-1:0]  step_id_q, step_id_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic [N_REQ-1:0] pb_p0_q, pb_p1_q, pb_p2_q;

  logic [N_REQ-1:0] press;
  logic [N_REQ-1:0] grant_clr;
  logic [ID_W:0]    pick;
  logic             arb;
  logic             drop;

  // Returns {found, id}: first requester at or after last+1, wrapping modulo N_REQ.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                            input logic [ID_W-1:0]  last);
    logic            found;
    logic [ID_W-1:0] id;
    int              idx;
    found = 1'b0;
    id    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        id    = ID_W'(idx);
      end
    end
    return {found, id};
  endfunction

  // Stage boundary: p0/p1 synchronise the raw levels, p2 holds the previous level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pb_p0_q   <= '0;
      pb_p1_q   <= '0;
      pb_p2_q   <= '0;
      pend_q    <= '0;
      ovf_q     <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= LAST_RST;
      step_en_q <= 1'b0;
      step_id_q <= '0;
    end else begin
      pb_p0_q   <= pb;
      pb_p1_q   <= pb_p0_q;
      pb_p2_q   <= pb_p1_q;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      step_en_q <= step_en_d;
      step_id_q <= step_id_d;
    end
  end

  assign press = pb_p1_q & ~pb_p2_q;

  // The last HOLD cycle arbitrates like IDLE so consecutive grants sit exactly GAP idle cycles apart.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    step_en_d = 1'b0;
    step_id_d = '0;
    grant_clr = '0;
    arb       = 1'b0;
    pick      = rr_pick(pend_q, last_q);
    case (state_q)
      IDLE: arb = 1'b1;
      GRANT: begin
        if (GAP == 0) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          arb     = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (arb && pick[ID_W]) begin
      state_d   = GRANT;
      step_en_d = 1'b1;
      step_id_d = pick[ID_W-1:0];
      last_d    = pick[ID_W-1:0];
      grant_clr = N_REQ'(1) << pick[ID_W-1:0];
    end
  end

  // A press coinciding with its own grant re-arms the flag; only a press onto a live flag is dropped.
  always_comb begin
    pend_d = (pend_q & ~grant_clr) | press;
    drop   = |(press & pend_q & ~grant_clr);
    ovf_d  = drop | (ovf_q & ~clr_ovf);
  end

  assign step_en  = step_en_q;
  assign step_id  = step_id_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pb_step_scheduler.sv
// Directed bench for pb_step_scheduler (N_REQ=4, GAP=2): grants are checked
// against a scoreboard of expected {id, cycle} pairs pushed as stimulus is driven.
module tb_pb_step_scheduler;

  localparam int N_REQ = 4;
  localparam int GAP   = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_REQ-1:0] pb;
  logic             clr_ovf;
  logic             step_en;
  logic [1:0]       step_id;
  logic [N_REQ-1:0] pending;
  logic             overflow;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;
  int exp_id_q[$];
  int exp_cyc_q[$];

  pb_step_scheduler #(.N_REQ(N_REQ), .GAP(GAP)) dut (
    .clk      (clk),
    .reset    (reset),
    .pb       (pb),
    .clr_ovf  (clr_ovf),
    .step_en  (step_en),
    .step_id  (step_id),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input int c);
    exp_id_q.push_back(id);
    exp_cyc_q.push_back(c);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drained(input string tag);
    check(tag, 32'(exp_id_q.size()), 32'd0);
    exp_id_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b0;
    pb      = '0;
    clr_ovf = 1'b0;
    tick(2);
    exp_id_q.delete();
    exp_cyc_q.delete();
    reset = 1'b1;
  endtask

  // Scoreboard consumer: every step_en pulse must match the oldest expected grant.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (step_en === 1'b1) begin
        if (exp_id_q.size() == 0) begin
          check("unexpected_grant", 32'(step_en), 32'd0);
        end else begin
          check("grant_id", 32'(step_id), 32'(exp_id_q.pop_front()));
          check("grant_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
        end
      end else begin
        check("idle_step_id", 32'(step_id), 32'd0);
      end
    end
  end

  initial begin
    int k;
    reset   = 1'b1;
    pb      = '0;
    clr_ovf = 1'b0;
    #2 reset = 1'b0;
    tick(3);
    check("rst_step_en", 32'(step_en), 32'd0);
    check("rst_step_id", 32'(step_id), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;

    // Single button held for 30 cycles: one grant, 3 edges after first sample.
    @(negedge clk);
    k  = cyc;
    pb = 4'b0001;
    push(0, k + 4);
    tick(3);
    check("hold_pending_set", 32'(pending), 32'h1);
    tick(1);
    check("hold_pending_clr", 32'(pending), 32'h0);
    tick(26);
    pb = '0;
    tick(5);
    check("hold_pending_end", 32'(pending), 32'h0);
    drained("hold_drained");

    // All four pressed on one edge: ids 0..3, GAP+1 cycles apart.
    do_reset();
    k  = cyc;
    pb = 4'b1111;
    push(0, k + 4);
    push(1, k + 7);
    push(2, k + 10);
    push(3, k + 13);
    tick(1);
    pb = '0;
    tick(2);
    check("all_pending", 32'(pending), 32'hF);
    tick(12);
    check("all_overflow", 32'(overflow), 32'h0);
    check("all_pending_end", 32'(pending), 32'h0);
    drained("all_drained");

    // Round robin resumes after the last winner: 2, then 3, then 0.
    do_reset();
    k  = cyc;
    pb = 4'b0100;
    push(2, k + 4);
    push(3, k + 7);
    push(0, k + 10);
    tick(1);
    pb = 4'b1001;
    tick(1);
    pb = '0;
    tick(2);
    check("rr_pending", 32'(pending), 32'h9);
    tick(9);
    check("rr_pending_end", 32'(pending), 32'h0);
    drained("rr_drained");

    // Re-press of a still-pending button is dropped and flagged; clr_ovf clears it.
    do_reset();
    k  = cyc;
    pb = 4'b0011;
    push(0, k + 4);
    push(1, k + 7);
    tick(1);
    pb = 4'b0001;
    tick(2);
    pb = 4'b0011;
    tick(2);
    check("drop_ovf_before", 32'(overflow), 32'h0);
    tick(1);
    check("drop_ovf_set", 32'(overflow), 32'h1);
    check("drop_pending", 32'(pending), 32'h2);
    tick(4);
    pb = '0;
    check("drop_pending_end", 32'(pending), 32'h0);
    tick(5);
    check("drop_ovf_sticky", 32'(overflow), 32'h1);
    clr_ovf = 1'b1;
    check("drop_ovf_pre_clr", 32'(overflow), 32'h1);
    tick(1);
    clr_ovf = 1'b0;
    check("drop_ovf_cleared", 32'(overflow), 32'h0);
    drained("drop_drained");

    // Reset during HOLD with two requests pending: outputs clear at once, nothing follows.
    do_reset();
    k  = cyc;
    pb = 4'b0111;
    push(0, k + 4);
    tick(1);
    pb = '0;
    tick(4);
    check("hold_rst_pending_before", 32'(pending), 32'h6);
    reset = 1'b0;
    #1;
    check("hold_rst_step_en", 32'(step_en), 32'h0);
    check("hold_rst_step_id", 32'(step_id), 32'h0);
    check("hold_rst_pending", 32'(pending), 32'h0);
    check("hold_rst_overflow", 32'(overflow), 32'h0);
    tick(2);
    reset = 1'b1;
    tick(20);
    check("hold_rst_pending_end", 32'(pending), 32'h0);
    drained("hold_rst_drained");

    // Reset while step_en is high terminates the grant immediately.
    do_reset();
    pb = 4'b0001;
    tick(1);
    pb = '0;
    tick(2);
    @(posedge clk);
    #1;
    check("abort_step_en_before", 32'(step_en), 32'h1);
    reset = 1'b0;
    #1;
    check("abort_step_en", 32'(step_en), 32'h0);
    check("abort_step_id", 32'(step_id), 32'h0);
    tick(2);
    reset = 1'b1;
    tick(15);
    check("abort_pending_end", 32'(pending), 32'h0);
    drained("abort_drained");

    // Re-press of id 3 lands on the cycle its grant clears pending[3]: set wins.
    do_reset();
    k  = cyc;
    pb = 4'b1001;
    push(0, k + 4);
    push(3, k + 7);
    push(3, k + 10);
    tick(3);
    pb = 4'b0000;
    tick(1);
    pb = 4'b1000;
    tick(3);
    check("coinc_pending", 32'(pending), 32'h8);
    check("coinc_overflow", 32'(overflow), 32'h0);
    tick(3);
    check("coinc_pending_after", 32'(pending), 32'h0);
    tick(2);
    pb = '0;
    tick(5);
    check("coinc_overflow_end", 32'(overflow), 32'h0);
    check("coinc_pending_end", 32'(pending), 32'h0);
    drained("coinc_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
